// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the writeback scheduler: register index and data
// widths, the grant-source encoding and the holding-entry layout.
package rf_wb_sched_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    // Which requester wins the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LSU  = 2'd2
    } grant_src_e;

    // One pending writeback: destination index and result value.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // One-hot mask selecting a single register in the busy bitmap.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/rf_wb_sched_wb_slot.sv
// Single-entry valid/ready holding register for one writeback requester.
// The entry can be drained and refilled on the same edge, while in_ready
// keeps showing the full state for that cycle.
module wb_slot
    import rf_wb_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]      in_data,
    input  logic                 pop,
    output logic                 full,
    output wb_entry_t            entry
);

    logic capture;

    assign in_ready = !full;
    assign capture  = in_valid && (!full || pop);

    // Entry storage: load on capture, free on pop, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the payload is reset too, so a discarded entry never leaks stale data onto the write port.
            full  <= 1'b0;
            entry <= '0;
        end else if (capture) begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values, regardless of block order.
            full       <= 1'b1;
            entry.rd   <= in_rd;
            entry.data <= in_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: arbitrates ALU and LSU results onto a single
// register-file write port (LSU first, with an ALU anti-starvation limit)
// and tracks pending destinations in a busy scoreboard for hazard queries.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [XLEN-1:0]        alu_rd,
    input  logic signed [XLEN-1:0] alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [XLEN-1:0]        lsu_rd,
    input  logic signed [XLEN-1:0] lsu_data,
    output logic                   rf_we,
    output logic [XLEN-1:0]        rf_rd,
    output logic signed [XLEN-1:0] rf_data,
    input  logic                   issue_valid,
    input  logic [XLEN-1:0]        issue_rd,
    input  logic [XLEN-1:0]        rs1_addr,
    input  logic [XLEN-1:0]        rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                 alu_full;
    logic                 lsu_full;
    wb_entry_t            alu_entry;
    wb_entry_t            lsu_entry;
    logic                 alu_pop;
    logic                 lsu_pop;
    grant_src_e           grant;
    wb_entry_t            sel_entry;
    logic [CNT_W-1:0]     starve_cnt;
    logic [CNT_W-1:0]     starve_cnt_next;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_next;
    logic [NUM_REGS-1:0]  set_mask;
    logic [NUM_REGS-1:0]  clr_mask;

    // Only the low index bits address the register file; the rest are ignored.
    logic unused_bits;
    assign unused_bits = ^{alu_rd[XLEN-1:REG_IDX_W], lsu_rd[XLEN-1:REG_IDX_W],
                           issue_rd[XLEN-1:REG_IDX_W], rs1_addr[XLEN-1:REG_IDX_W],
                           rs2_addr[XLEN-1:REG_IDX_W]};

    assign alu_pop = (grant == GRANT_ALU);
    assign lsu_pop = (grant == GRANT_LSU);

    wb_slot u_alu_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd[REG_IDX_W-1:0]),
        .in_data  (alu_data),
        .pop      (alu_pop),
        .full     (alu_full),
        .entry    (alu_entry)
    );

    wb_slot u_lsu_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (lsu_valid),
        .in_ready (lsu_ready),
        .in_rd    (lsu_rd[REG_IDX_W-1:0]),
        .in_data  (lsu_data),
        .pop      (lsu_pop),
        .full     (lsu_full),
        .entry    (lsu_entry)
    );

    // Pick one full entry: LSU first unless the ALU has waited out its limit.
    always_comb begin
        // NOTE: defaults first guarantee every path assigns, so no latch is inferred.
        grant     = GRANT_NONE;
        sel_entry = '0;
        if (lsu_full && !(alu_full && starve_cnt == STARVE_MAX)) begin
            grant     = GRANT_LSU;
            sel_entry = lsu_entry;
        end else if (alu_full) begin
            grant     = GRANT_ALU;
            sel_entry = alu_entry;
        end
    end

    // Count LSU wins while the ALU waits; reset once the ALU is served or idle.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!alu_full || grant == GRANT_ALU) begin
            starve_cnt_next = '0;
        end else if (grant == GRANT_LSU && starve_cnt != STARVE_MAX) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end

    // Registered write port; a grant to x0 frees the entry but writes nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= (grant != GRANT_NONE) && (sel_entry.rd != '0);
            if (grant != GRANT_NONE) begin
                rf_rd   <= {{(XLEN-REG_IDX_W){1'b0}}, sel_entry.rd};
                rf_data <= sel_entry.data;
            end
        end
    end

    // Busy bitmap update: issue sets, writeback clears, set wins, x0 never busy.
    always_comb begin
        set_mask     = issue_valid ? idx_onehot(issue_rd[REG_IDX_W-1:0]) : '0;
        clr_mask     = rf_we ? idx_onehot(rf_rd[REG_IDX_W-1:0]) : '0;
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    // Busy bitmap register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard query, treating the write currently on the port as already done.
    assign rs1_busy = busy[rs1_addr[REG_IDX_W-1:0]]
                      && !(rf_we && rf_rd[REG_IDX_W-1:0] == rs1_addr[REG_IDX_W-1:0]);
    assign rs2_busy = busy[rs2_addr[REG_IDX_W-1:0]]
                      && !(rf_we && rf_rd[REG_IDX_W-1:0] == rs2_addr[REG_IDX_W-1:0]);

endmodule
